// File: rtl/rhd_pkg.sv
// Shared definitions for the RHD2000 SPI link: opcodes, special command words,
// ROM register map and the responder state encoding.
package rhd_pkg;

  localparam logic [1:0] OP_CONVERT = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_CLEAR     = 16'h6A00;

  localparam int          RAM_DEPTH     = 22;
  localparam logic [5:0]  RAM_LAST_ADDR = 6'd21;

  localparam logic [5:0] ROM_INTAN_I   = 6'd40;
  localparam logic [5:0] ROM_INTAN_N0  = 6'd41;
  localparam logic [5:0] ROM_INTAN_T   = 6'd42;
  localparam logic [5:0] ROM_INTAN_A   = 6'd43;
  localparam logic [5:0] ROM_INTAN_N1  = 6'd44;
  localparam logic [5:0] ROM_DIE_REV   = 6'd60;
  localparam logic [5:0] ROM_UNIPOLAR  = 6'd61;
  localparam logic [5:0] ROM_NUM_AMPS  = 6'd62;
  localparam logic [5:0] ROM_CHIP_ID   = 6'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rhd_state_e;

endpackage

// File: rtl/rhd_sync_edge.sv
// N-flop input synchronizer with single-cycle rise/fall pulses taken from
// the synchronized copy versus its one-cycle-old history.
module rhd_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;
  logic              cur_s;

  assign cur_s = sync_r[STAGES-1];
  assign rise  = cur_s & ~prev_r;
  assign fall  = ~cur_s & prev_r;

  // synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= cur_s;
    end
  end

endmodule

// File: rtl/rhd_spi_responder.sv
// RHD2000-style SPI slave emulator: decodes 16-bit commands and returns each
// result two frames later on MISO, with a small register RAM and fixed ROM.
module rhd_spi_responder
  import rhd_pkg::*;
#(
  parameter int unsigned CHIP_ID     = 1,
  parameter int unsigned NUM_AMPS    = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        CS,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  output logic        frame_err,
  output logic [9:0]  frame_cnt
);

  localparam logic [7:0]  CHIP_ID_B  = 8'(CHIP_ID);
  localparam logic [7:0]  NUM_AMPS_B = 8'(NUM_AMPS);
  localparam int unsigned AMPS_CAP   = (NUM_AMPS > 64) ? 64 : NUM_AMPS;
  localparam logic [6:0]  AMPS_LIM_C = 7'(AMPS_CAP);

  rhd_state_e              state_r, state_nxt_s;
  logic                    cs_rise_s, cs_fall_s, sclk_rise_s, sclk_fall_s;
  logic [SYNC_STAGES-1:0]  mosi_sync_r;
  logic                    mosi_s;
  logic [4:0]              bit_cnt_r;
  logic [15:0]             rx_sr_r, tx_sr_r;
  logic [15:0]             pipe_p1_r, pipe_p2_r;
  logic [7:0]              ram_r [RAM_DEPTH];
  logic                    load_tx_s, shift_rx_s, shift_tx_s, err_s, commit_s;
  logic [5:0]              addr_s;
  logic [7:0]              rd_val_s;
  logic [15:0]             result_s;
  logic                    ram_we_s;

  rhd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rstn(rstn), .din(CS), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  rhd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .din(SCLK), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
  assign MISO   = tx_sr_r[15];
  assign addr_s = rx_sr_r[13:8];

  // MOSI needs no edge detect, only the same synchronizer depth as SCLK
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_sync_r[0] <= MOSI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mosi_sync_r[i] <= mosi_sync_r[i-1];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state and datapath strobes; a CS rise masks any coincident SCLK edge
  always_comb begin
    state_nxt_s = state_r;
    load_tx_s   = 1'b0;
    shift_rx_s  = 1'b0;
    shift_tx_s  = 1'b0;
    err_s       = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          load_tx_s   = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          if (bit_cnt_r == 5'd16) begin
            state_nxt_s = DONE;
          end else begin
            err_s       = 1'b1;
            state_nxt_s = IDLE;
          end
        end else if (sclk_rise_s) begin
          shift_rx_s = 1'b1;
        end else if (sclk_fall_s) begin
          shift_tx_s = 1'b1;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        commit_s    = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // register RAM plus fixed ROM map
  always_comb begin
    rd_val_s = 8'h00;
    if (addr_s <= RAM_LAST_ADDR) begin
      rd_val_s = ram_r[addr_s[4:0]];
    end else begin
      case (addr_s)
        ROM_INTAN_I:  rd_val_s = 8'h49;
        ROM_INTAN_N0: rd_val_s = 8'h4E;
        ROM_INTAN_T:  rd_val_s = 8'h54;
        ROM_INTAN_A:  rd_val_s = 8'h41;
        ROM_INTAN_N1: rd_val_s = 8'h4E;
        ROM_DIE_REV:  rd_val_s = 8'h01;
        ROM_UNIPOLAR: rd_val_s = 8'h00;
        ROM_NUM_AMPS: rd_val_s = NUM_AMPS_B;
        ROM_CHIP_ID:  rd_val_s = CHIP_ID_B;
        default:      rd_val_s = 8'h00;
      endcase
    end
  end

  // command decode; CONVERT reports the pre-increment frame count
  always_comb begin
    result_s = 16'h0000;
    ram_we_s = 1'b0;
    case (rx_sr_r[15:14])
      OP_CONVERT: begin
        if ({1'b0, addr_s} < AMPS_LIM_C) begin
          result_s = {addr_s, frame_cnt};
        end else begin
          result_s = 16'h0000;
        end
      end
      OP_WRITE: begin
        result_s = {8'hFF, rx_sr_r[7:0]};
        ram_we_s = (addr_s <= RAM_LAST_ADDR);
      end
      OP_READ: begin
        result_s = {8'h00, rd_val_s};
      end
      default: begin
        if (rx_sr_r == CMD_CALIBRATE) begin
          result_s = 16'h8000;
        end else begin
          result_s = 16'h0000;
        end
      end
    endcase
  end

  // shift registers; tx_sr is zeroed outside a frame so MISO idles low
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_r <= 5'd0;
      rx_sr_r   <= 16'h0000;
      tx_sr_r   <= 16'h0000;
    end else if (load_tx_s) begin
      bit_cnt_r <= 5'd0;
      tx_sr_r   <= pipe_p2_r;
    end else if (shift_rx_s) begin
      rx_sr_r <= {rx_sr_r[14:0], mosi_s};
      if (bit_cnt_r != 5'd31) begin
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end else if (shift_tx_s) begin
      tx_sr_r <= {tx_sr_r[14:0], 1'b0};
    end else if (state_r != SHIFT) begin
      tx_sr_r <= 16'h0000;
    end else begin
      tx_sr_r <= tx_sr_r;
    end
  end

  // frame commit: pipeline, status outputs and frame counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_p1_r <= 16'h0000;
      pipe_p2_r <= 16'h0000;
      cmd_word  <= 16'h0000;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= 10'd0;
    end else begin
      cmd_valid <= commit_s;
      frame_err <= err_s;
      if (commit_s) begin
        pipe_p2_r <= pipe_p1_r;
        pipe_p1_r <= result_s;
        cmd_word  <= rx_sr_r;
        frame_cnt <= frame_cnt + 10'd1;
      end else begin
        pipe_p2_r <= pipe_p2_r;
      end
    end
  end

  // register RAM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        ram_r[i] <= 8'h00;
      end
    end else if (commit_s && ram_we_s) begin
      ram_r[addr_s[4:0]] <= rx_sr_r[7:0];
    end else begin
      ram_r[0] <= ram_r[0];
    end
  end

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Scoreboard bench: the driver pushes expected MISO words and command records
// from a behavioural RHD model; a clocked monitor pops and compares them.
module tb_rhd_spi_responder;

  localparam int HALF = 5;
  localparam int GAP  = 6;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        CS   = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        frame_err;
  logic [9:0]  frame_cnt;

  always #5 clk = ~clk;

  rhd_spi_responder #(.CHIP_ID(1), .NUM_AMPS(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // behavioural chip model
  logic [7:0]  m_regs [22];
  logic [15:0] m_hist [$];
  int          m_cnt;
  string       m_intan = "INTAN";

  // scoreboard
  logic [15:0] miso_q [$];
  logic [25:0] cmd_q  [$];
  int          exp_err = 0;
  int          exp_cmds = 0;
  bit          done = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 22; i++) m_regs[i] = 8'h00;
    m_hist.delete();
    m_cnt = 0;
  endtask

  function automatic logic [7:0] model_read(input int a);
    if (a <= 21) return m_regs[a];
    if (a >= 40 && a <= 44) return 8'(m_intan[a-40]);
    if (a == 60) return 8'h01;
    if (a == 62) return 8'd32;
    if (a == 63) return 8'd1;
    return 8'h00;
  endfunction

  task automatic model_exec(input logic [15:0] w, output logic [15:0] r);
    int a;
    a = int'(w[13:8]);
    case (w[15:14])
      2'b00: r = (a < 32) ? {w[13:8], 10'(m_cnt)} : 16'h0000;
      2'b10: begin
        if (a <= 21) m_regs[a] = w[7:0];
        r = {8'hFF, w[7:0]};
      end
      2'b11: r = {8'h00, model_read(a)};
      default: r = (w == 16'h5500) ? 16'h8000 : 16'h0000;
    endcase
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    CS = 1'b0; SCLK = 1'b1;
    repeat (2) @(negedge clk);
    SCLK = 1'b0; CS = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits = 16,
                            input bit cs_with_sclk = 1'b0, input int abort_after = -1);
    logic [15:0] r;
    if (abort_after < 0) begin
      if (nbits == 16) begin
        miso_q.push_back((m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 16'h0000);
        model_exec(w, r);
        m_hist.push_back(r);
        m_cnt = (m_cnt + 1) % 1024;
        cmd_q.push_back({w, 10'(m_cnt)});
        exp_cmds++;
      end else begin
        exp_err++;
      end
    end
    @(negedge clk);
    CS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      if (b == abort_after) begin
        rstn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        return;
      end
      MOSI = (b < 16) ? w[15-b] : 1'b0;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    CS = 1'b1;
    if (cs_with_sclk) begin
      SCLK = 1'b1;
      repeat (2) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (GAP) @(negedge clk);
  endtask

  // monitor: samples 2 ns after the active edge, well before inputs move
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  int          mon_bits = 0;
  logic [15:0] mon_word = 16'h0000;
  int          err_seen = 0;
  int          cmd_seen = 0;

  always @(posedge clk) begin
    #2;
    if (!rstn) begin
      check("rst_miso", 32'(MISO), 32'd0);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_word", 32'(cmd_word), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      mon_bits = 0;
    end else begin
      if (cs_prev && !CS) begin
        mon_bits = 0;
        mon_word = 16'h0000;
      end
      if (!sclk_prev && SCLK && !CS) begin
        mon_word = {mon_word[14:0], MISO};
        mon_bits++;
      end
      if (!cs_prev && CS && mon_bits == 16) begin
        if (miso_q.size() == 0) check("miso_unexpected_frame", 32'd1, 32'd0);
        else check("miso_word", 32'(mon_word), 32'(miso_q.pop_front()));
      end
      if (cmd_valid) begin
        cmd_seen++;
        if (cmd_q.size() == 0) check("cmd_valid_unexpected", 32'd1, 32'd0);
        else check("cmd_word_frame_cnt", 32'({cmd_word, frame_cnt}), 32'(cmd_q.pop_front()));
      end
      if (frame_err) err_seen++;
      if (done) begin
        check("frame_err_count", 32'(err_seen), 32'(exp_err));
        check("cmd_valid_count", 32'(cmd_seen), 32'(exp_cmds));
        check("miso_queue_drained", 32'(miso_q.size()), 32'd0);
        check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
    cs_prev   = CS;
    sclk_prev = SCLK;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [15:0] w;
    model_reset();
    @(negedge clk);
    do_reset();

    // ROM reads through the two-frame pipeline
    send_frame(16'hFF00);
    send_frame(16'hE800);
    send_frame(16'hFF00);
    send_frame(16'hFF00);

    // RAM write then read-back
    send_frame(16'h85A5);
    send_frame(16'hC500);
    send_frame(16'hC500);
    send_frame(16'hC500);

    // CONVERT count embedding after exactly 7 prior frames
    do_reset();
    repeat (7) send_frame(16'hFF00);
    send_frame(16'h0301);
    send_frame(16'hFF00);
    send_frame(16'hFF00);
    send_frame(16'h2800);
    send_frame(16'hFF00);
    send_frame(16'hFF00);

    // framing boundaries: short, long, CS rise coincident with SCLK rise
    send_frame(16'h8177, 12);
    send_frame(16'hFF00);
    send_frame(16'h8277, 20);
    send_frame(16'hC100);
    send_frame(16'h8399, 16, 1'b1);
    send_frame(16'hC300);
    send_frame(16'hC300);

    // type-01 commands
    send_frame(16'h5500);
    send_frame(16'h6A00);
    send_frame(16'h4123);
    send_frame(16'hFF00);
    send_frame(16'hFF00);

    // reset in the middle of a WRITE
    send_frame(16'h803C, 16, 1'b0, 8);
    repeat (3) send_frame(16'hC000);

    // randomized mix
    for (int k = 0; k < 80; k++) begin
      op = 2'($urandom_range(0, 3));
      case (op)
        2'b00:   w = {2'b00, 6'($urandom_range(0, 63)), 8'($urandom)};
        2'b01:   w = ($urandom_range(0, 2) == 0) ? 16'h5500 :
                     ($urandom_range(0, 1) == 0) ? 16'h6A00 : {2'b01, 14'($urandom)};
        default: w = {op, 6'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 21)
                                                          : $urandom_range(0, 63)), 8'($urandom)};
      endcase
      send_frame(w);
    end
    send_frame(16'hFF00);
    send_frame(16'hFF00);
    repeat (10) @(negedge clk);
    done = 1'b1;
  end

endmodule
